// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: branch condition codes, flag indices and the flag vector type
package pc_sequencer_pkg;
    localparam logic [2:0] BT_BRZ    = 3'd0;
    localparam logic [2:0] BT_BRN    = 3'd1;
    localparam logic [2:0] BT_BRNZ   = 3'd2;
    localparam logic [2:0] BT_BRP    = 3'd3;
    localparam logic [2:0] BT_BRC    = 3'd4;
    localparam logic [2:0] BT_BRV    = 3'd5;
    localparam logic [2:0] BT_ALWAYS = 3'd6;
    localparam logic [2:0] BT_NEVER  = 3'd7;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef logic [3:0] flags_t;
endpackage

// File: rtl/pc_sequencer_branch_cond_eval.sv
// branch_cond_eval: combinational evaluation of the eight branch conditions
module branch_cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] btype,
    input  flags_t     flags,
    output logic       cond
);
    logic [7:0] table_bits;
    // one bit per condition code, indexed by btype; code 0 is plain Z
    always_comb begin
        table_bits = {1'b0, 1'b1, flags[FLAG_V], flags[FLAG_C],
                      !flags[FLAG_N] && !flags[FLAG_Z], !flags[FLAG_Z],
                      flags[FLAG_N], flags[FLAG_Z]};
        cond = table_bits[btype];
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, flag register and one-deep pending redirect buffer
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] PC_INC      = PC_W'(1),
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              FLAG_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_stall,
    input  logic            in_branch,
    input  logic            in_jump,
    input  logic [2:0]      in_btype,
    input  logic [PC_W-1:0] in_target,
    input  logic            in_flags_we,
    input  logic            in_neg,
    input  logic            in_zero,
    input  logic            in_carry,
    input  logic            in_ovf,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_next_seq,
    output logic            out_taken,
    output logic            out_flush,
    output logic            out_pending
);
    flags_t          flag_q;
    flags_t          flag_in;
    flags_t          flag_eff;
    logic            cond;
    logic [PC_W-1:0] pend_target;

    // gather ALU flags and pick the source used for this cycle's condition
    always_comb begin
        flag_in         = '0;
        flag_in[FLAG_N] = in_neg;
        flag_in[FLAG_Z] = in_zero;
        flag_in[FLAG_C] = in_carry;
        flag_in[FLAG_V] = in_ovf;
        flag_eff        = (FLAG_BYPASS != 0 && in_flags_we) ? flag_in : flag_q;
    end

    branch_cond_eval u_cond (
        .btype (in_btype),
        .flags (flag_eff),
        .cond  (cond)
    );

    assign out_pc_next_seq = out_pc + PC_INC;
    assign out_taken       = !out_pending && (in_jump || (in_branch && cond));

    // flag register loads whenever written, independent of stall
    always_ff @(posedge clk) begin
        if (rst)
            flag_q <= '0;
        else if (in_flags_we)
            flag_q <= flag_in;
    end

    // PC update: drain pending redirect first, capture redirects raised under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc      <= RESET_PC;
            out_pending <= 1'b0;
            pend_target <= '0;
            out_flush   <= 1'b0;
        end else if (out_pending && !in_stall) begin
            out_pc      <= pend_target;
            out_pending <= 1'b0;
            out_flush   <= 1'b1;
        end else if (in_stall) begin
            out_flush <= 1'b0;
            if (out_taken) begin
                out_pending <= 1'b1;
                pend_target <= in_target;
            end
        end else if (out_taken) begin
            out_pc    <= in_target;
            out_flush <= 1'b1;
        end else begin
            out_pc    <= out_pc_next_seq;
            out_flush <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench running a bypass and a non-bypass instance against a reference model
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, fwe = 1'b0;
    logic        n = 1'b0, z = 1'b0, c = 1'b0, v = 1'b0;
    logic [2:0]  btype = 3'd0;
    logic [31:0] target = 32'd0;
    logic [31:0] pc_o [2];
    logic [31:0] seq_o [2];
    logic        taken_o [2];
    logic        flush_o [2];
    logic        pend_o [2];

    typedef struct { int inst; logic [31:0] pc; logic flush; logic pend; } rexp_t;
    typedef struct { int inst; logic taken; logic [31:0] seq; } cexp_t;
    rexp_t rq [$];
    cexp_t cq [$];

    int pass = 0, total = 0;

    logic [31:0] m_pc [2];
    logic [3:0]  m_flags [2];
    logic        m_pend [2];
    logic [31:0] m_tgt [2];
    logic        m_flush [2];
    logic        known = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(32), .PC_INC(32'h4), .RESET_PC(32'h100), .FLAG_BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .in_stall(stall), .in_branch(branch), .in_jump(jump),
        .in_btype(btype), .in_target(target), .in_flags_we(fwe), .in_neg(n),
        .in_zero(z), .in_carry(c), .in_ovf(v), .out_pc(pc_o[0]),
        .out_pc_next_seq(seq_o[0]), .out_taken(taken_o[0]), .out_flush(flush_o[0]),
        .out_pending(pend_o[0])
    );

    pc_sequencer #(.PC_W(32), .PC_INC(32'h4), .RESET_PC(32'h100), .FLAG_BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .in_stall(stall), .in_branch(branch), .in_jump(jump),
        .in_btype(btype), .in_target(target), .in_flags_we(fwe), .in_neg(n),
        .in_zero(z), .in_carry(c), .in_ovf(v), .out_pc(pc_o[1]),
        .out_pc_next_seq(seq_o[1]), .out_taken(taken_o[1]), .out_flush(flush_o[1]),
        .out_pending(pend_o[1])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, inst, $time, act, exp);
    endtask

    // flags as {N,Z,C,V}
    function automatic logic cond_of(input logic [2:0] bt, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (bt)
            3'd0: return fz;
            3'd1: return fn;
            3'd2: return !fz;
            3'd3: return !fn && !fz;
            3'd4: return fc;
            3'd5: return fv;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // drive one cycle of inputs at negedge, predict both instances, queue expectations
    task automatic step(input logic r, input logic s, input logic br, input logic j,
                        input logic [2:0] bt, input logic [31:0] tg, input logic we,
                        input logic [3:0] f);
        @(negedge clk);
        rst = r; stall = s; branch = br; jump = j; btype = bt; target = tg; fwe = we;
        {n, z, c, v} = f;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] eff;
            logic tk;
            eff = (i == 0 && we) ? f : m_flags[i];
            tk = !m_pend[i] && (j || (br && cond_of(bt, eff)));
            if (known && !r) cq.push_back('{i, tk, m_pc[i] + 32'd4});
            if (r) begin
                m_pc[i] = 32'h100; m_flags[i] = 4'd0; m_pend[i] = 1'b0;
                m_tgt[i] = 32'd0; m_flush[i] = 1'b0;
            end else begin
                if (we) m_flags[i] = f;
                if (m_pend[i] && !s) begin
                    m_pc[i] = m_tgt[i]; m_pend[i] = 1'b0; m_flush[i] = 1'b1;
                end else if (s) begin
                    m_flush[i] = 1'b0;
                    if (tk) begin m_pend[i] = 1'b1; m_tgt[i] = tg; end
                end else if (tk) begin
                    m_pc[i] = tg; m_flush[i] = 1'b1;
                end else begin
                    m_pc[i] = m_pc[i] + 32'd4; m_flush[i] = 1'b0;
                end
            end
            rq.push_back('{i, m_pc[i], m_flush[i], m_pend[i]});
        end
        if (r) known = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0);
    endtask

    // combinational outputs, checked once inputs have settled
    initial forever begin
        @(negedge clk);
        #2;
        while (cq.size() > 0) begin
            cexp_t e;
            e = cq.pop_front();
            chk("taken", e.inst, 32'(taken_o[e.inst]), 32'(e.taken));
            chk("next_seq", e.inst, seq_o[e.inst], e.seq);
        end
    end

    // registered outputs, checked just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        while (rq.size() > 0) begin
            rexp_t e;
            e = rq.pop_front();
            chk("pc", e.inst, pc_o[e.inst], e.pc);
            chk("flush", e.inst, 32'(flush_o[e.inst]), 32'(e.flush));
            chk("pending", e.inst, 32'(pend_o[e.inst]), 32'(e.pend));
        end
    end

    initial begin
        step(1, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0);
        step(1, 0, 0, 0, 3'd0, 32'd0, 0, 4'd0);
        idle(4);
        step(0, 0, 1, 0, 3'd0, 32'h200, 1, 4'b0100);
        idle(1);
        step(0, 0, 0, 0, 3'd0, 32'd0, 1, 4'b1000);
        step(0, 0, 1, 0, 3'd3, 32'h300, 0, 4'd0);
        step(0, 0, 1, 0, 3'd1, 32'h300, 0, 4'd0);
        step(0, 0, 1, 0, 3'd7, 32'h300, 0, 4'd0);
        step(0, 0, 1, 0, 3'd6, 32'h300, 0, 4'd0);
        idle(1);
        step(0, 1, 0, 1, 3'd0, 32'h400, 0, 4'd0);
        step(0, 1, 1, 0, 3'd0, 32'h500, 1, 4'b0100);
        step(0, 1, 0, 0, 3'd0, 32'd0, 0, 4'd0);
        idle(2);
        step(0, 0, 0, 1, 3'd0, 32'hFFFF_FFFC, 0, 4'd0);
        idle(2);
        step(0, 1, 0, 1, 3'd0, 32'h600, 0, 4'd0);
        step(1, 1, 0, 0, 3'd0, 32'd0, 0, 4'd0);
        idle(2);
        for (int k = 0; k < 600; k++)
            step($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 35,
                 $urandom_range(99) < 12, 3'($urandom_range(7)), $urandom,
                 $urandom_range(99) < 30, 4'($urandom_range(15)));
        idle(1);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the single-bit PC-select logic.
- Owns the program counter register and a condition-flag register, and evaluates eight branch conditions.
- Holds a one-deep pending-redirect buffer so a taken branch or jump raised during a stall is not lost.
- Sits between the decode/control unit (branch, jump, btype, target) and instruction fetch (out_pc); also drives the pipeline flush.

Parameters:
- PC_W, 32, width of the PC and branch target.
- PC_INC, 1, sequential PC increment, added modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- FLAG_BYPASS, 1, selects the flag source for this cycle's condition. 1: flags being written this cycle feed the condition evaluation. 0: only the registered flags are used.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_stall  in  1  hold the PC; fetch is not accepting.
- in_branch  in  1  conditional branch request.
- in_jump  in  1  unconditional redirect request.
- in_btype  in  3  branch condition select (encoding in Behaviour).
- in_target  in  PC_W  redirect target address.
- in_flags_we  in  1  write enable for the flag register.
- in_neg, in_zero, in_carry, in_ovf  in  1 each  ALU flags N, Z, C, V.
- out_pc  out  PC_W  current fetch PC (registered).
- out_pc_next_seq  out  PC_W  out_pc + PC_INC (combinational; used for link).
- out_taken  out  1  combinational redirect decision for this cycle.
- out_flush  out  1  registered; 1 for exactly the cycle after the PC loads a redirect target.
- out_pending  out  1  registered; pending-redirect buffer is occupied.

Behaviour:
- Reset values: out_pc=RESET_PC; flags N,Z,C,V=0; pending=0; pending target=0; out_flush=0. Reset overrides every other input in the same cycle, including a pending redirect mid-stall.
- Effective flags F:
  - If FLAG_BYPASS=1 and in_flags_we=1, F = the incoming flag inputs.
  - Otherwise F = the flag register.
- Flag register loads the inputs when in_flags_we=1, regardless of stall.
- Condition cond(btype, F):
  - 0 BRZ: Z.
  - 1 BRN: N.
  - 2 BRNZ: !Z.
  - 3 BRP: !N && !Z.
  - 4 BRC: C.
  - 5 BRV: V.
  - 6 ALWAYS: 1.
  - 7 NEVER: 0.
  - Code 0 keeps legacy BRZ semantics: Z alone, with no N qualification.
- out_taken = !pending && (in_jump || (in_branch && cond)). If jump and branch are both high, jump wins; the target is in_target either way.
- PC update priority, highest first:
  1. rst.
  2. pending && !in_stall: pc <= pending target; pending <= 0; out_flush <= 1. Requests in this cycle are wrong-path and ignored.
  3. in_stall && out_taken: pc holds; pending <= 1; pending target <= in_target; out_flush <= 0.
  4. in_stall: pc holds; pending holds; out_flush <= 0.
  5. out_taken: pc <= in_target; out_flush <= 1.
  6. Otherwise: pc <= pc + PC_INC, wrapping modulo 2^PC_W; out_flush <= 0.
- While pending=1, new branch and jump requests are ignored (out_taken=0); the buffer never overwrites.
- Redirect latency: target appears on out_pc one cycle after an unstalled taken request. For a stalled request it appears one cycle after stall deasserts.
- out_flush is never high for two consecutive cycles unless two redirects load on consecutive cycles.
- in_target is used unaligned; no masking.

Decomposition:
- Shared package:
  - btype localparams BT_BRZ..BT_NEVER (3-bit).
  - Flag index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
  - A 4-bit flags_t typedef.
- One natural sub-module, branch_cond_eval: purely combinational; inputs btype and flags_t; output cond. Reusable by a future branch predictor checker.
- PC register, flag register and pending buffer stay in pc_sequencer.

Test Plan:
- Reset, then 4 idle cycles, RESET_PC=0x100, PC_INC=4 -> out_pc 0x100, 0x104, 0x108, 0x10C; out_flush=0 throughout.
- Write flags Z=1 with in_flags_we and BRZ (btype 0) to 0x200 in the same cycle, FLAG_BYPASS=1 -> out_taken=1; next cycle out_pc=0x200 and out_flush=1. Repeat with FLAG_BYPASS=0 and stale Z=0 -> not taken, out_pc=pc+4.
- Registered flags N=1, Z=0: BRP to 0x300 -> not taken. BRN -> taken. NEVER -> not taken. ALWAYS -> taken.
- Stall held 3 cycles while a jump to 0x400 is raised in stall cycle 1:
  - out_pending=1 from cycle 2.
  - A BRZ raised in stall cycle 2 is ignored.
  - out_pc holds the same value through the stall.
  - The cycle after stall drops, out_pc=0x400 and out_flush=1.
- PC=0xFFFFFFFC, PC_W=32, PC_INC=4, idle -> next out_pc=0x00000000.
- pending=1, then rst asserted with stall still high -> next cycle out_pc=RESET_PC, out_pending=0, out_flush=0.
